// File: rtl/voting_pkg.sv
// Shared definitions for the N-candidate ballot controller.
//   state_t : FSM state encoding (also driven out on state_o)
//   idx_w   : candidate index width for a given candidate count
//   tot_w   : width of the vote total (wide enough for NUM_CAND saturated counters)
package voting_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED = 3'd0,
    ST_ARMED  = 3'd1,
    ST_REARM  = 3'd2,
    ST_TALLY  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  function automatic int idx_w(input int num_cand);
    return (num_cand < 2) ? 1 : $clog2(num_cand);
  endfunction

  function automatic int tot_w(input int num_cand, input int cnt_w);
    return cnt_w + idx_w(num_cand);
  endfunction

endpackage

// File: rtl/vote_tally_scan.sv
// Sequential max / tie / total scanner.
// A start pulse (on the edge that enters the tally phase) clears the accumulators;
// afterwards one candidate is examined per cycle, skipping ineligible ones.
//   clk, rst  : clock, synchronous active-high reset
//   start     : 1-cycle pulse, restarts the scan at candidate 0
//   counts    : flat per-candidate counters, candidate i at [i*CNT_W +: CNT_W]
//   eligible  : candidates taking part in the scan
//   done      : high during the cycle that examines the last candidate
//   max_idx   : first index holding the maximum (includes the current candidate)
//   max_cnt   : maximum count, stable once the scan has finished
//   tie       : two or more eligible candidates share the maximum
//   total     : sum of eligible counters (includes the current candidate)
module vote_tally_scan
  import voting_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 7,
  parameter int IDX_W    = 2,
  parameter int TOT_W    = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_CAND*CNT_W-1:0] counts,
  input  logic [NUM_CAND-1:0]       eligible,
  output logic                      done,
  output logic [IDX_W-1:0]          max_idx,
  output logic [CNT_W-1:0]          max_cnt,
  output logic                      tie,
  output logic [TOT_W-1:0]          total
);

  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             seen_q, seen_d;
  logic             dup_q, dup_d;
  logic [IDX_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [TOT_W-1:0] sum_q, sum_d;

  logic [CNT_W-1:0] cur_cnt;
  logic             cur_elig;
  logic             last;
  logic             upd_seen, upd_dup;
  logic [IDX_W-1:0] upd_best;
  logic [CNT_W-1:0] upd_max;
  logic [TOT_W-1:0] upd_sum;

  always_comb begin
    cur_cnt  = '0;
    cur_elig = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_cnt  = counts[i*CNT_W +: CNT_W];
        cur_elig = eligible[i];
      end
    end
  end

  assign last = (idx_q == IDX_W'(NUM_CAND - 1));

  // Accumulators with the current candidate folded in. Kept separate from the
  // start handling so the outputs depend on registered state only.
  always_comb begin
    upd_seen = seen_q;
    upd_dup  = dup_q;
    upd_best = best_q;
    upd_max  = max_q;
    upd_sum  = sum_q;
    if (cur_elig) begin
      upd_sum = sum_q + TOT_W'(cur_cnt);
      // Strictly greater replaces the leader, so the first maximum wins ties.
      if (!seen_q || (cur_cnt > max_q)) begin
        upd_seen = 1'b1;
        upd_max  = cur_cnt;
        upd_best = idx_q;
        upd_dup  = 1'b0;
      end else if (cur_cnt == max_q) begin
        upd_dup = 1'b1;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    seen_d = seen_q;
    dup_d  = dup_q;
    best_d = best_q;
    max_d  = max_q;
    sum_d  = sum_q;
    if (start) begin
      busy_d = 1'b1;
      idx_d  = '0;
      seen_d = 1'b0;
      dup_d  = 1'b0;
      best_d = '0;
      max_d  = '0;
      sum_d  = '0;
    end else if (busy_q) begin
      seen_d = upd_seen;
      dup_d  = upd_dup;
      best_d = upd_best;
      max_d  = upd_max;
      sum_d  = upd_sum;
      if (last) begin
        busy_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      seen_q <= 1'b0;
      dup_q  <= 1'b0;
      best_q <= '0;
      max_q  <= '0;
      sum_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      seen_q <= seen_d;
      dup_q  <= dup_d;
      best_q <= best_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
    end
  end

  assign done    = busy_q && last;
  assign max_idx = upd_best;
  assign max_cnt = max_q;
  assign tie     = upd_dup;
  assign total   = upd_sum;

endmodule

// File: rtl/voting_machine_n.sv
// N-candidate ballot controller: key-armed single ballots, saturating counters,
// sequential tally with winner/tie detection and optional runoff among tied candidates.
//   clk, rst   : clock, synchronous active-high reset
//   key_val    : key input; KEY_CODE arms one ballot
//   vote_req   : ballot strobe, vote_sel = candidate index
//   vote_done  : close the poll and start the tally
//   vote_ack   : 1-cycle pulse, ballot counted
//   vote_nack  : 1-cycle pulse, ballot rejected
//   counts     : flat counters, candidate i at [i*CNT_W +: CNT_W]
//   total      : sum of eligible counts (RESULT)
//   win_idx    : winner, or first maximum on a tie
//   win_valid  : unique winner (RESULT)
//   tie        : shared maximum (RESULT)
//   eligible   : candidates currently accepting votes
//   sat        : sticky, some counter saturated
//   state_o    : FSM state encoding
module voting_machine_n
  import voting_pkg::*;
#(
  parameter int               NUM_CAND  = 4,
  parameter int               CNT_W     = 7,
  parameter int               KEY_W     = 4,
  parameter logic [KEY_W-1:0] KEY_CODE  = {KEY_W{1'b1}},
  parameter bit               RUNOFF_EN = 1'b1,
  localparam int              IDX_W     = idx_w(NUM_CAND),
  localparam int              TOT_W     = tot_w(NUM_CAND, CNT_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_W-1:0]          key_val,
  input  logic                      vote_req,
  input  logic [IDX_W-1:0]          vote_sel,
  input  logic                      vote_done,
  output logic                      vote_ack,
  output logic                      vote_nack,
  output logic [NUM_CAND*CNT_W-1:0] counts,
  output logic [TOT_W-1:0]          total,
  output logic [IDX_W-1:0]          win_idx,
  output logic                      win_valid,
  output logic                      tie,
  output logic [NUM_CAND-1:0]       eligible,
  output logic                      sat,
  output logic [2:0]                state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CAND];
  logic [CNT_W-1:0]    cnt_d [NUM_CAND];
  logic [NUM_CAND-1:0] elig_q, elig_d;
  logic                ack_q, ack_d, nack_q, nack_d;
  logic                sat_q, sat_d;
  logic                win_valid_q, win_valid_d, tie_q, tie_d;
  logic [IDX_W-1:0]    win_idx_q, win_idx_d;
  logic [TOT_W-1:0]    total_q, total_d;

  logic [NUM_CAND*CNT_W-1:0] counts_flat;
  logic [NUM_CAND-1:0]       tied_mask;
  logic                      sel_ok;
  logic                      scan_start, scan_done, scan_tie;
  logic [IDX_W-1:0]          scan_max_idx;
  logic [CNT_W-1:0]          scan_max_cnt;
  logic [TOT_W-1:0]          scan_total;

  // After a scan the scanner holds the maximum, so the tied set is every
  // eligible candidate sitting at that value.
  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
    assign counts_flat[gi*CNT_W +: CNT_W] = cnt_q[gi];
    assign tied_mask[gi] = elig_q[gi] && (cnt_q[gi] == scan_max_cnt);
  end

  // Indices past NUM_CAND match no candidate and are rejected.
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_sel == IDX_W'(i)) sel_ok = elig_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    elig_d      = elig_q;
    ack_d       = 1'b0;
    nack_d      = 1'b0;
    sat_d       = sat_q;
    win_valid_d = win_valid_q;
    tie_d       = tie_q;
    win_idx_d   = win_idx_q;
    total_d     = total_q;
    unique case (state_q)
      ST_LOCKED: begin
        nack_d = vote_req;
        if (vote_done) state_d = ST_TALLY;
        else if (key_val == KEY_CODE) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (vote_req) begin
          if (sel_ok) begin
            ack_d   = 1'b1;
            state_d = ST_REARM;
            for (int i = 0; i < NUM_CAND; i++) begin
              if (vote_sel == IDX_W'(i)) begin
                if (cnt_q[i] == CNT_MAX) sat_d = 1'b1;
                else cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end else begin
            nack_d = 1'b1;
          end
        end
        // The ballot above is still counted when the poll closes this cycle.
        if (vote_done) state_d = ST_TALLY;
      end
      ST_REARM: begin
        nack_d = vote_req;
        if (vote_done) state_d = ST_TALLY;
        else if (key_val != KEY_CODE) state_d = ST_LOCKED;
      end
      ST_TALLY: begin
        nack_d = vote_req;
        if (scan_done) begin
          state_d     = ST_RESULT;
          win_idx_d   = scan_max_idx;
          tie_d       = scan_tie;
          win_valid_d = !scan_tie;
          total_d     = scan_total;
        end
      end
      ST_RESULT: begin
        nack_d = vote_req;
        if (RUNOFF_EN && tie_q) begin
          elig_d      = tied_mask;
          cnt_d       = '{default: '0};
          total_d     = '0;
          tie_d       = 1'b0;
          win_valid_d = 1'b0;
          win_idx_d   = '0;
          state_d     = ST_LOCKED;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  assign scan_start = (state_d == ST_TALLY) && (state_q != ST_TALLY);

  vote_tally_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W),
    .TOT_W    (TOT_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .start    (scan_start),
    .counts   (counts_flat),
    .eligible (elig_q),
    .done     (scan_done),
    .max_idx  (scan_max_idx),
    .max_cnt  (scan_max_cnt),
    .tie      (scan_tie),
    .total    (scan_total)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOCKED;
      cnt_q       <= '{default: '0};
      elig_q      <= '1;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      sat_q       <= 1'b0;
      win_valid_q <= 1'b0;
      tie_q       <= 1'b0;
      win_idx_q   <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      elig_q      <= elig_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      sat_q       <= sat_d;
      win_valid_q <= win_valid_d;
      tie_q       <= tie_d;
      win_idx_q   <= win_idx_d;
      total_q     <= total_d;
    end
  end

  assign vote_ack  = ack_q;
  assign vote_nack = nack_q;
  assign counts    = counts_flat;
  assign total     = total_q;
  assign win_idx   = win_idx_q;
  assign win_valid = win_valid_q;
  assign tie       = tie_q;
  assign eligible  = elig_q;
  assign sat       = sat_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_voting_machine_n.sv
// Bench for voting_machine_n (4 candidates, 3-bit counters so saturation is reachable).
// Directed scenarios followed by random polls, all checked against a vote-level model.
module tb_voting_machine_n;
  import voting_pkg::*;

  localparam int NC = 4;
  localparam int CW = 3;
  localparam int IW = 2;
  localparam int TW = CW + IW;
  localparam logic [3:0] KEY = 4'hF;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       key_val = '0;
  logic             vote_req = 1'b0;
  logic [IW-1:0]    vote_sel = '0;
  logic             vote_done = 1'b0;
  logic             vote_ack, vote_nack, win_valid, tie, sat;
  logic [NC*CW-1:0] counts;
  logic [TW-1:0]    total;
  logic [IW-1:0]    win_idx;
  logic [NC-1:0]    eligible;
  logic [2:0]       state_o;

  voting_machine_n #(
    .NUM_CAND (NC),
    .CNT_W    (CW),
    .KEY_W    (4),
    .KEY_CODE (KEY),
    .RUNOFF_EN(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_val  (key_val),
    .vote_req (vote_req),
    .vote_sel (vote_sel),
    .vote_done(vote_done),
    .vote_ack (vote_ack),
    .vote_nack(vote_nack),
    .counts   (counts),
    .total    (total),
    .win_idx  (win_idx),
    .win_valid(win_valid),
    .tie      (tie),
    .eligible (eligible),
    .sat      (sat),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Vote-level model of the poll.
  int          m_cnt [NC];
  bit [NC-1:0] m_elig;
  bit          m_sat;
  bit          m_armed;
  bit          last_tie;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return 32'(counts[i*CW +: CW]);
  endfunction

  task automatic chk_counts(input string tag);
    for (int i = 0; i < NC; i++) chk(tag, cnt_of(i), 32'(m_cnt[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1; key_val = '0; vote_req = 1'b0; vote_done = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_elig = '1; m_sat = 1'b0; m_armed = 1'b0;
    chk("rst_state", state_o, ST_LOCKED);
    chk_counts("rst_counts");
    chk("rst_total", total, 0);
    chk("rst_win_idx", win_idx, 0);
    chk("rst_eligible", eligible, m_elig);
    chk("rst_flags", {vote_ack, vote_nack, win_valid, tie, sat}, 0);
    $display("reset: state=%0d eligible=%b", state_o, eligible);
  endtask

  // One ballot: arm if needed, present the vote, check the handshake, release the key.
  task automatic vote(input int sel);
    bit ok;
    if (!m_armed) begin
      key_val = KEY;
      step();
      chk("arm_state", state_o, ST_ARMED);
      m_armed = 1'b1;
    end
    vote_req = 1'b1; vote_sel = IW'(sel);
    step();
    vote_req = 1'b0;
    ok = m_elig[sel];
    if (ok) begin
      if (m_cnt[sel] == (1 << CW) - 1) m_sat = 1'b1;
      else m_cnt[sel]++;
    end
    chk("vote_ack", vote_ack, ok);
    chk("vote_nack", vote_nack, !ok);
    chk("vote_count", cnt_of(sel), 32'(m_cnt[sel]));
    chk("vote_sat", sat, m_sat);
    $display("vote sel=%0d ack=%0d nack=%0d count=%0d sat=%0d", sel, vote_ack, vote_nack, cnt_of(sel), sat);
    if (ok) begin
      chk("vote_rearm", state_o, ST_REARM);
      key_val = '0;
      step();
      chk("vote_relock", state_o, ST_LOCKED);
      m_armed = 1'b0;
    end else begin
      chk("vote_retry", state_o, ST_ARMED);
    end
  endtask

  task automatic unarmed_vote(input int sel);
    vote_req = 1'b1; vote_sel = IW'(sel); key_val = '0;
    step();
    vote_req = 1'b0;
    chk("locked_nack", {vote_ack, vote_nack}, 2'b01);
    chk("locked_state", state_o, ST_LOCKED);
    chk("locked_count", cnt_of(sel), 32'(m_cnt[sel]));
    $display("unarmed vote sel=%0d nack=%0d", sel, vote_nack);
  endtask

  // Wait out the scan after the poll has closed and check the result.
  task automatic finish_tally();
    int mi, tot, maxv, nmax;
    bit [NC-1:0] mask;
    for (int i = 1; i < NC; i++) begin
      step();
      chk("tally_hold", state_o, ST_TALLY);
    end
    step();
    chk("result_state", state_o, ST_RESULT);
    maxv = -1; mi = 0; tot = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_elig[i]) begin
        tot += m_cnt[i];
        if (m_cnt[i] > maxv) begin maxv = m_cnt[i]; mi = i; end
      end
    end
    nmax = 0; mask = '0;
    for (int i = 0; i < NC; i++) begin
      if (m_elig[i] && m_cnt[i] == maxv) begin nmax++; mask[i] = 1'b1; end
    end
    last_tie = (nmax >= 2);
    chk("res_win_idx", win_idx, mi);
    chk("res_tie", tie, last_tie);
    chk("res_win_valid", win_valid, !last_tie);
    chk("res_total", total, tot);
    $display("tally: win_idx=%0d win_valid=%0d tie=%0d total=%0d", win_idx, win_valid, tie, total);
    step();
    if (last_tie) begin
      m_elig = mask;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      chk("runoff_state", state_o, ST_LOCKED);
      chk("runoff_eligible", eligible, mask);
      chk("runoff_total", total, 0);
      chk("runoff_flags", {tie, win_valid}, 2'b00);
      chk_counts("runoff_counts");
      $display("runoff: eligible=%b", eligible);
    end else begin
      chk("result_hold", state_o, ST_RESULT);
      chk("result_hold_win", win_valid, 1);
    end
  endtask

  task automatic tally();
    key_val = '0; vote_done = 1'b1;
    step();
    vote_done = 1'b0;
    m_armed = 1'b0;
    chk("tally_enter", state_o, ST_TALLY);
    finish_tally();
  endtask

  initial begin
    // First ballot, then a held key must not arm a second one.
    do_reset();
    key_val = KEY;
    step();
    chk("t1_armed", state_o, ST_ARMED);
    vote_req = 1'b1; vote_sel = 2'd2;
    step();
    chk("t1_ack", {vote_ack, vote_nack}, 2'b10);
    chk("t1_count", cnt_of(2), 1);
    chk("t1_rearm", state_o, ST_REARM);
    step();
    chk("t1_held_nack", {vote_ack, vote_nack}, 2'b01);
    chk("t1_held_count", cnt_of(2), 1);
    chk("t1_held_state", state_o, ST_REARM);
    vote_req = 1'b0; key_val = '0;
    step();
    chk("t1_locked", state_o, ST_LOCKED);
    $display("t1: single ballot per arming, count=%0d", cnt_of(2));

    // Unique winner.
    do_reset();
    for (int i = 0; i < 3; i++) vote(0);
    vote(1);
    vote(3); vote(3);
    tally();

    // Tie, runoff among A/B, ineligible C rejected, B wins.
    do_reset();
    vote(0); vote(0); vote(1); vote(1); vote(2);
    tally();
    chk("t3_runoff_mask", eligible, 4'b0011);
    vote(2);
    vote(1);
    tally();
    chk("t3_winner", win_idx, 1);

    // Saturation: all nine acked, count held at 7.
    do_reset();
    for (int i = 0; i < 9; i++) vote(2);
    chk("t4_sat_count", cnt_of(2), 7);
    chk("t4_sat", sat, 1);

    // Ballot and poll close in the same cycle.
    do_reset();
    key_val = KEY;
    step();
    vote_req = 1'b1; vote_sel = 2'd1; vote_done = 1'b1; key_val = '0;
    step();
    vote_req = 1'b0; vote_done = 1'b0;
    m_cnt[1] = 1;
    chk("t5_ack", vote_ack, 1);
    chk("t5_count", cnt_of(1), 1);
    chk("t5_tally", state_o, ST_TALLY);
    finish_tally();

    // Reset two cycles into a runoff tally.
    do_reset();
    vote(0); vote(1);
    tally();
    vote(0);
    key_val = '0; vote_done = 1'b1;
    step();
    vote_done = 1'b0;
    step();
    chk("t6_mid_tally", state_o, ST_TALLY);
    do_reset();

    // Random polls, runoffs followed until a unique winner.
    for (int r = 0; r < 25; r++) begin
      int nv;
      nv = $urandom_range(0, 14);
      for (int v = 0; v < nv; v++) begin
        if (!m_armed && $urandom_range(0, 7) == 0) unarmed_vote($urandom_range(0, NC - 1));
        vote($urandom_range(0, NC - 1));
      end
      tally();
      if (!last_tie) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
